lsu_mem_port: RTL and testbench

- Load/store unit sitting directly upstream of the single-port word-wide data RAM (generic_ram, WIDTH=32, READ_OLD=1, combinational read).
- Accepts RISC-V load/store requests over a valid/ready handshake and drives RAM addr/data/write_en.
- Performs byte-lane extraction with sign or zero extension for loads.
- Performs read-modify-write for SB/SH, checks alignment, and returns one response per request.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_mem_port_if.sv | 46 ++++
 rtl/lsu_lane_align.sv | 52 +++++
 rtl/lsu_mem_port.sv | 135 +++++++++++++
 tb/tb_lsu_mem_port.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared definitions for the load/store unit: RISC-V funct3
//             encodings, FSM state encoding and the request legality check.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_MERGE_WR = 2'd2,
    ST_RESP     = 2'd3
  } lsu_state_e;

  // A request is legal when funct3 names a real width, unsigned widths are
  // only used by loads, and the address is naturally aligned for its width.
  function automatic logic is_legal(input logic       we,
                                    input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_port_if
//  Purpose  : Request/response handshake plus RAM-side bus of the LSU.
//  Ports    : req_*  request channel (valid/ready)
//             rsp_*  response channel (valid/ready)
//             ram_*  word-wide single-port RAM connection
//  Modports : master - request source / response sink / RAM model
//             slave  - the load/store unit
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_mem_port_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
);
  localparam int RAM_AW = $clog2(DEPTH);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic              ram_write_en;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_data_w;
  logic [31:0]       ram_data_r;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, ram_data_r,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_write_en, ram_addr, ram_data_w
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, ram_data_r,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_write_en, ram_addr, ram_data_w
  );

endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_lane_align
//  Purpose  : Combinational byte-lane logic (little-endian).
//  Ports    : i_word    RAM word read at the access address
//             i_wdata   store data (low bits used for B/H)
//             i_addr_lo byte offset within the word
//             i_funct3  access width / signedness
//             o_load    extracted and sign/zero-extended load result
//             o_merged  i_word with the store lane(s) replaced by i_wdata
//  Revision : 1.0  initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'h0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'h0, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    case (i_funct3)
      F3_B: o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      F3_H: begin
        if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
        else              o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_port
//  Purpose  : Load/store unit in front of a single-port word-wide RAM with
//             combinational read. One request outstanding at a time; B/H
//             stores use a read-modify-write over two RAM cycles.
//  Ports    : clock   single clock, posedge
//             reset_n asynchronous active-low reset
//             bus     lsu_mem_port_if.slave (request, response, RAM)
//  Revision : 1.0  initial release
// ============================================================================
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input logic           clock,
  input logic           reset_n,
  lsu_mem_port_if.slave bus
);

  localparam int RAM_AW = $clog2(DEPTH);

  lsu_state_e        r_state;
  lsu_state_e        w_next_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [RAM_AW+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_merge;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_legal;
  logic              w_req_ready;
  logic              w_rsp_valid;
  logic              w_ram_we;
  logic [31:0]       w_ram_wd;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  // Address bits above the RAM range are deliberately dropped (wrap).
  logic              w_unused_addr;
  assign w_unused_addr = ^bus.req_addr[ADDR_W-1:RAM_AW+2];

  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;
  assign w_legal  = is_legal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  lsu_lane_align u_lane_align (
    .i_word    (bus.ram_data_r),
    .i_wdata   (r_wdata),
    .i_addr_lo (r_addr[1:0]),
    .i_funct3  (r_funct3),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_wd     = 32'h0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_next_state = w_legal ? ST_ACCESS : ST_RESP;
      end
      ST_ACCESS: begin
        if (r_we && (r_funct3 == F3_W)) begin
          w_ram_we     = 1'b1;
          w_ram_wd     = r_wdata;
          w_next_state = ST_RESP;
        end else if (r_we) begin
          w_next_state = ST_MERGE_WR;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      ST_MERGE_WR: begin
        w_ram_we     = 1'b1;
        w_ram_wd     = r_merge;
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_merge  <= 32'h0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= bus.req_we;
        r_funct3 <= bus.req_funct3;
        r_addr   <= bus.req_addr[RAM_AW+1:0];
        r_wdata  <= bus.req_wdata;
        r_rdata  <= 32'h0;
        r_err    <= ~w_legal;
      end
      if (r_state == ST_ACCESS) begin
        if (!r_we) r_rdata <= w_load;
        r_merge <= w_merged;
      end
    end
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.rsp_valid    = w_rsp_valid;
  // Response fields read as zero whenever no response is being offered.
  assign bus.rsp_rdata    = w_rsp_valid ? r_rdata : 32'h0;
  assign bus.rsp_err      = w_rsp_valid & r_err;
  assign bus.ram_write_en = w_ram_we;
  assign bus.ram_addr     = r_addr[RAM_AW+1:2];
  assign bus.ram_data_w   = w_ram_wd;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_mem_port
//  Purpose  : Directed self-checking bench for lsu_mem_port with a RAM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_mem_port;
  import lsu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  lsu_mem_port_if #(.ADDR_W(32), .DEPTH(1024)) bus ();

  lsu_mem_port #(.DEPTH(1024), .ADDR_W(32)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, write on posedge; preload port for the bench.
  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  assign bus.ram_data_r = mem[bus.ram_addr];

  always @(posedge clk) begin
    if (pre_we)                mem[pre_addr]     <= pre_data;
    else if (bus.ram_write_en) mem[bus.ram_addr] <= bus.ram_data_w;
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Presents one request for one edge; returns in the cycle after acceptance.
  task automatic send(input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Cycles (1 = cycle after acceptance) until rsp_valid; 0 on timeout.
  // mask bit k records ram_write_en seen in cycle k.
  task automatic wait_rsp(output int lat, output logic [15:0] mask);
    int k;
    lat = 0; mask = '0; k = 1;
    while (lat == 0 && k <= 8) begin
      if (bus.ram_write_en) mask[k] = 1'b1;
      if (bus.rsp_valid) lat = k;
      else begin
        @(negedge clk);
        k++;
      end
    end
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); end
    n_checks++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    n_checks++; if (bus.ram_write_en !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we: got %b want 0", bus.ram_write_en); end
    n_checks++; if (bus.ram_addr !== 10'h0) begin n_fail++; $display("FAIL rst_ram_addr: got %h want 0", bus.ram_addr); end
    n_checks++; if (bus.ram_data_w !== 32'h0) begin n_fail++; $display("FAIL rst_ram_data_w: got %h want 0", bus.ram_data_w); end
    preload(10'd1, 32'h8899AABB);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [2:0]  ld_f3   [0:6] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W, F3_B, F3_BU};
  logic [31:0] ld_addr [0:6] = '{32'd5, 32'd5, 32'd6, 32'd6, 32'd4, 32'd4, 32'd7};
  logic [31:0] ld_exp  [0:6] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899,
                                 32'h8899AABB, 32'hFFFFFFBB, 32'h00000088};

  task automatic test_loads();
    int lat; logic [15:0] mask;
    for (int i = 0; i < 7; i++) begin
      send(1'b0, ld_f3[i], ld_addr[i], 32'h0);
      wait_rsp(lat, mask);
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL load%0d_latency: got %0d want 2", i, lat); end
      n_checks++; if (bus.rsp_rdata !== ld_exp[i]) begin n_fail++; $display("FAIL load%0d_rdata: got %h want %h", i, bus.rsp_rdata, ld_exp[i]); end
      n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL load%0d_err: got %b want 0", i, bus.rsp_err); end
      n_checks++; if (mask !== 16'h0) begin n_fail++; $display("FAIL load%0d_no_write: got %h want 0", i, mask); end
      ack();
    end
  endtask

  task automatic test_sub_stores();
    int lat; logic [15:0] mask;
    send(1'b1, F3_B, 32'd4, 32'h12345612);
    wait_rsp(lat, mask);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL sb_latency: got %0d want 3", lat); end
    n_checks++; if (mask !== 16'h0004) begin n_fail++; $display("FAIL sb_write_cycle: got %h want 0004", mask); end
    n_checks++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL sb_rsp: got rdata %h err %b want 0/0", bus.rsp_rdata, bus.rsp_err); end
    ack();
    n_checks++; if (mem[1] !== 32'h8899AA12) begin n_fail++; $display("FAIL sb_word: got %h want 8899aa12", mem[1]); end

    preload(10'd1, 32'h8899AABB);
    send(1'b1, F3_H, 32'd6, 32'h0000CAFE);
    wait_rsp(lat, mask);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL sh_latency: got %0d want 3", lat); end
    n_checks++; if (mask !== 16'h0004) begin n_fail++; $display("FAIL sh_write_cycle: got %h want 0004", mask); end
    ack();
    n_checks++; if (mem[1] !== 32'hCAFEAABB) begin n_fail++; $display("FAIL sh_word: got %h want cafeaabb", mem[1]); end
  endtask

  task automatic test_sw_and_wrap();
    int lat; logic [15:0] mask;
    send(1'b1, F3_W, 32'd4, 32'hDEADBEEF);
    wait_rsp(lat, mask);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", lat); end
    n_checks++; if (mask !== 16'h0002) begin n_fail++; $display("FAIL sw_write_cycle: got %h want 0002", mask); end
    ack();
    n_checks++; if (mem[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_word: got %h want deadbeef", mem[1]); end

    // Byte address 0x1007 lies beyond 1024 words and wraps onto word 1, byte 3.
    send(1'b1, F3_B, 32'h00001007, 32'h00000077);
    wait_rsp(lat, mask);
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b want 0", bus.rsp_err); end
    ack();
    n_checks++; if (mem[1] !== 32'h77ADBEEF) begin n_fail++; $display("FAIL wrap_word: got %h want 77adbeef", mem[1]); end
  endtask

  logic        er_we   [0:3] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [2:0]  er_f3   [0:3] = '{F3_W, F3_H, 3'b100, 3'b011};
  logic [31:0] er_addr [0:3] = '{32'd6, 32'd5, 32'd4, 32'd4};

  task automatic test_errors();
    int lat; logic [15:0] mask; logic [31:0] snap;
    for (int i = 0; i < 4; i++) begin
      snap = mem[1];
      send(er_we[i], er_f3[i], er_addr[i], 32'hFFFFFFFF);
      wait_rsp(lat, mask);
      n_checks++; if (lat != 1) begin n_fail++; $display("FAIL err%0d_latency: got %0d want 1", i, lat); end
      n_checks++; if (bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL err%0d_flag: got %b want 1", i, bus.rsp_err); end
      n_checks++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL err%0d_rdata: got %h want 0", i, bus.rsp_rdata); end
      n_checks++; if (mask !== 16'h0) begin n_fail++; $display("FAIL err%0d_no_write: got %h want 0", i, mask); end
      ack();
      n_checks++; if (mem[1] !== snap) begin n_fail++; $display("FAIL err%0d_word: got %h want %h", i, mem[1], snap); end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] mask;
    send(1'b0, F3_W, 32'd4, 32'h0);
    wait_rsp(lat, mask);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL bp_latency: got %0d want 2", lat); end
    // Second request held pending while the response is stalled.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_BU; bus.req_addr = 32'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_valid: got %b want 1", i, bus.rsp_valid); end
      n_checks++; if (bus.rsp_rdata !== 32'h77ADBEEF) begin n_fail++; $display("FAIL bp%0d_rdata: got %h want 77adbeef", i, bus.rsp_rdata); end
      n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d_req_ready: got %b want 0", i, bus.req_ready); end
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_on_ack: got %b want 0", bus.req_ready); end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got valid %b ready %b want 0/1", bus.rsp_valid, bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_rsp(lat, mask);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL b2b_latency: got %0d want 2", lat); end
    n_checks++; if (bus.rsp_rdata !== 32'h000000EF) begin n_fail++; $display("FAIL b2b_rdata: got %h want 000000ef", bus.rsp_rdata); end
    ack();
  endtask

  task automatic test_reset_mid_rmw();
    int lat; logic [15:0] mask; logic [31:0] snap;
    snap = mem[1];
    send(1'b1, F3_B, 32'd4, 32'h00000055);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_handshake: got ready %b valid %b want 1/0", bus.req_ready, bus.rsp_valid); end
    n_checks++; if (bus.ram_write_en !== 1'b0 || bus.ram_addr !== 10'h0 || bus.ram_data_w !== 32'h0) begin n_fail++; $display("FAIL mid_rst_ram: got we %b addr %h data %h want 0/0/0", bus.ram_write_en, bus.ram_addr, bus.ram_data_w); end
    n_checks++; if (bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rst_rsp: got err %b rdata %h want 0/0", bus.rsp_err, bus.rsp_rdata); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (mem[1] !== snap) begin n_fail++; $display("FAIL mid_rst_word: got %h want %h", mem[1], snap); end
    send(1'b0, F3_W, 32'd4, 32'h0);
    wait_rsp(lat, mask);
    n_checks++; if (lat != 2 || bus.rsp_rdata !== snap) begin n_fail++; $display("FAIL mid_rst_reload: got lat %0d rdata %h want 2/%h", lat, bus.rsp_rdata, snap); end
    ack();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_loads();
    test_sub_stores();
    test_sw_and_wrap();
    test_errors();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
